// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl
//   Sequences an external bank of W T flip-flops as a binary counter.
//   A run clears the bank, then drives increment toggle masks until the bank
//   reaches the latched limit. One-shot runs finish with a single done pulse
//   and leave the bank at the limit. Auto-reload runs fold the bank back to
//   zero and count wraps (saturating at 255).
//
// Ports
//   clk     : rising-edge clock for all state
//   rst     : synchronous active-high reset
//   start   : begin a run (accepted in IDLE only)
//   stop    : abort an active run (CLEAR or COUNT)
//   mode    : 0 one-shot, 1 auto-reload; sampled with start
//   limit   : terminal count; sampled with start
//   q_in    : q outputs of the external TFF bank
//   t_en    : t inputs of the external TFF bank
//   tff_rst : synchronous clear of the external TFF bank
//   busy    : high in CLEAR and COUNT
//   done    : one-cycle pulse when a one-shot run completes
//   wraps   : auto-reload wrap count, saturating
module tff_count_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         mode,
  input  logic [W-1:0] limit,
  input  logic [W-1:0] q_in,
  output logic [W-1:0] t_en,
  output logic         tff_rst,
  output logic         busy,
  output logic         done,
  output logic [7:0]   wraps
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state_q;
  logic [W-1:0] limit_q;
  logic         mode_q;
  logic [7:0]   wraps_q;

  logic         at_limit;
  logic [W-1:0] inc_mask;
  logic         carry;

  assign at_limit = (q_in == limit_q);

  // Toggle mask for a binary increment: bit i toggles when all lower bits are 1.
  always_comb begin
    inc_mask = '0;
    carry    = 1'b1;
    for (int unsigned i = 0; i < W; i++) begin
      inc_mask[i] = carry;
      carry       = carry & q_in[i];
    end
  end

  // Toggle drive is combinational so a stop or reset silences the bank in the
  // same cycle it is seen.
  always_comb begin
    t_en = '0;
    if (!rst && (state_q == COUNT) && !stop) begin
      if (at_limit) begin
        // Toggling every set bit returns the bank to zero on the next edge.
        if (mode_q) t_en = q_in;
      end else begin
        t_en = inc_mask;
      end
    end
  end

  // Status outputs decode the registered state; reset forces the bank clear
  // and masks busy/done so an abandoned run never reports completion.
  assign tff_rst = rst | (state_q == CLEAR);
  assign busy    = !rst && ((state_q == CLEAR) || (state_q == COUNT));
  assign done    = !rst && (state_q == DONE);
  assign wraps   = wraps_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      limit_q <= '0;
      mode_q  <= 1'b0;
      wraps_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            limit_q <= limit;
            mode_q  <= mode;
            wraps_q <= '0;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          state_q <= stop ? IDLE : COUNT;
        end
        COUNT: begin
          // Stop wins over the terminal-count check.
          if (stop) begin
            state_q <= IDLE;
          end else if (at_limit) begin
            if (mode_q) begin
              if (wraps_q != 8'hFF) wraps_q <= wraps_q + 8'd1;
            end else begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tff_count_ctrl.sv
module tb_tff_count_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       mode;
  logic [3:0] limit;
  logic [3:0] q;
  logic [3:0] t_en;
  logic       tff_rst;
  logic       busy;
  logic       done;
  logic [7:0] wraps;

  int checks;
  int failures;

  typedef struct packed {
    logic       r;
    logic       s;
    logic       p;
    logic       m;
    logic [3:0] l;
  } stim_t;

  stim_t       stq[$];
  logic [18:0] sb[$];

  logic [3:0] qe;
  logic [7:0] we;

  tff_count_ctrl #(.W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .mode   (mode),
    .limit  (limit),
    .q_in   (q),
    .t_en   (t_en),
    .tff_rst(tff_rst),
    .busy   (busy),
    .done   (done),
    .wraps  (wraps)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // External TFF bank model: toggles on t, clears on tff_rst.
  initial q = 4'd0;
  always @(posedge clk) begin
    if (tff_rst) q <= 4'd0;
    else         q <= q ^ t_en;
  end

  function automatic stim_t S(input logic r, input logic s, input logic p,
                              input logic m, input logic [3:0] l);
    stim_t v;
    v.r = r; v.s = s; v.p = p; v.m = m; v.l = l;
    return v;
  endfunction

  // Expected observation vector {q, t_en, tff_rst, busy, done, wraps}.
  function automatic logic [18:0] E(input logic [3:0] eq, input logic [3:0] et,
                                    input logic tr, input logic bz,
                                    input logic dn, input logic [7:0] ew);
    return {eq, et, tr, bz, dn, ew};
  endfunction

  function automatic logic [3:0] inc(input logic [3:0] v);
    logic [3:0] n;
    n = v + 4'd1;
    return v ^ n;
  endfunction

  function automatic void add(input stim_t s, input logic [18:0] e);
    stq.push_back(s);
    sb.push_back(e);
  endfunction

  task automatic test_reset;
    stim_t s; logic [18:0] ex, ob; int n;
    add(S(1,1,1,1,4'd7), E(4'd0, 4'd0, 1, 0, 0, 8'd0));
    add(S(1,0,0,0,4'd0), E(4'd0, 4'd0, 1, 0, 0, 8'd0));
    add(S(0,0,1,0,4'd0), E(4'd0, 4'd0, 0, 0, 0, 8'd0));
    qe = 4'd0; we = 8'd0;
    n = 0;
    while (stq.size() > 0) begin
      s = stq.pop_front();
      @(negedge clk);
      rst = s.r; start = s.s; stop = s.p; mode = s.m; limit = s.l;
      #1;
      ex = sb.pop_front();
      ob = {q, t_en, tff_rst, busy, done, wraps};
      checks++;
      if (ob !== ex) begin
        failures++;
        $display("FAIL reset cyc%0d got=%h exp=%h", n, ob, ex);
      end
      n++;
    end
  endtask

  task automatic test_oneshot;
    stim_t s; logic [18:0] ex, ob; int n;
    add(S(0,1,0,0,4'd5), E(qe, 4'd0, 0, 0, 0, we));
    // Limit/mode changes after start must not disturb the run.
    add(S(0,0,0,1,4'hA), E(qe, 4'd0, 1, 1, 0, 8'd0));
    for (int i = 0; i < 6; i++)
      add(S(0, i == 2, 0, 1, 4'hA),
          E(4'(i), (i == 5) ? 4'd0 : inc(4'(i)), 0, 1, 0, 8'd0));
    add(S(0,1,0,1,4'hA), E(4'd5, 4'd0, 0, 0, 1, 8'd0));
    add(S(0,0,0,0,4'd0), E(4'd5, 4'd0, 0, 0, 0, 8'd0));
    add(S(0,0,0,0,4'd0), E(4'd5, 4'd0, 0, 0, 0, 8'd0));
    qe = 4'd5; we = 8'd0;
    n = 0;
    while (stq.size() > 0) begin
      s = stq.pop_front();
      @(negedge clk);
      rst = s.r; start = s.s; stop = s.p; mode = s.m; limit = s.l;
      #1;
      ex = sb.pop_front();
      ob = {q, t_en, tff_rst, busy, done, wraps};
      checks++;
      if (ob !== ex) begin
        failures++;
        $display("FAIL oneshot cyc%0d got=%h exp=%h", n, ob, ex);
      end
      n++;
    end
  endtask

  task automatic test_autoreload;
    stim_t s; logic [18:0] ex, ob; int n; logic [3:0] qq; logic [7:0] w;
    add(S(0,1,0,1,4'd3), E(qe, 4'd0, 0, 0, 0, we));
    add(S(0,0,0,0,4'd1), E(qe, 4'd0, 1, 1, 0, 8'd0));
    w = 8'd0;
    for (int k = 0; k < 9; k++) begin
      qq = 4'(k % 4);
      add(S(0,0,0,0,4'd1), E(qq, (qq == 4'd3) ? qq : inc(qq), 0, 1, 0, w));
      if (qq == 4'd3) w = w + 8'd1;
    end
    add(S(0,0,1,0,4'd1), E(4'd1, 4'd0, 0, 1, 0, 8'd2));
    add(S(0,0,0,0,4'd1), E(4'd1, 4'd0, 0, 0, 0, 8'd2));
    qe = 4'd1; we = 8'd2;
    n = 0;
    while (stq.size() > 0) begin
      s = stq.pop_front();
      @(negedge clk);
      rst = s.r; start = s.s; stop = s.p; mode = s.m; limit = s.l;
      #1;
      ex = sb.pop_front();
      ob = {q, t_en, tff_rst, busy, done, wraps};
      checks++;
      if (ob !== ex) begin
        failures++;
        $display("FAIL autoreload cyc%0d got=%h exp=%h", n, ob, ex);
      end
      n++;
    end
  endtask

  task automatic test_stop;
    stim_t s; logic [18:0] ex, ob; int n;
    add(S(0,1,0,0,4'd9), E(qe, 4'd0, 0, 0, 0, we));
    add(S(0,0,0,0,4'd9), E(qe, 4'd0, 1, 1, 0, 8'd0));
    for (int i = 0; i < 4; i++)
      add(S(0,0,0,0,4'd9), E(4'(i), inc(4'(i)), 0, 1, 0, 8'd0));
    add(S(0,0,1,0,4'd9), E(4'd4, 4'd0, 0, 1, 0, 8'd0));
    add(S(0,0,1,0,4'd9), E(4'd4, 4'd0, 0, 0, 0, 8'd0));
    add(S(0,0,0,0,4'd9), E(4'd4, 4'd0, 0, 0, 0, 8'd0));
    qe = 4'd4; we = 8'd0;
    n = 0;
    while (stq.size() > 0) begin
      s = stq.pop_front();
      @(negedge clk);
      rst = s.r; start = s.s; stop = s.p; mode = s.m; limit = s.l;
      #1;
      ex = sb.pop_front();
      ob = {q, t_en, tff_rst, busy, done, wraps};
      checks++;
      if (ob !== ex) begin
        failures++;
        $display("FAIL stop cyc%0d got=%h exp=%h", n, ob, ex);
      end
      n++;
    end
  endtask

  task automatic test_reset_midrun;
    stim_t s; logic [18:0] ex, ob; int n; logic [3:0] qq; logic [7:0] w;
    add(S(0,1,0,1,4'd2), E(qe, 4'd0, 0, 0, 0, we));
    add(S(0,0,0,0,4'd0), E(qe, 4'd0, 1, 1, 0, 8'd0));
    w = 8'd0;
    for (int k = 0; k < 10; k++) begin
      qq = 4'(k % 3);
      add(S(0,0,0,0,4'd0), E(qq, (qq == 4'd2) ? qq : inc(qq), 0, 1, 0, w));
      if (qq == 4'd2) w = w + 8'd1;
    end
    // Reset with start held: start must be ignored.
    add(S(1,1,0,1,4'd6), E(4'd1, 4'd0, 1, 0, 0, 8'd3));
    // First IDLE after reset accepts a limit=0 one-shot.
    add(S(0,1,0,0,4'd0), E(4'd0, 4'd0, 0, 0, 0, 8'd0));
    add(S(0,0,0,0,4'd0), E(4'd0, 4'd0, 1, 1, 0, 8'd0));
    add(S(0,0,0,0,4'd0), E(4'd0, 4'd0, 0, 1, 0, 8'd0));
    add(S(0,0,0,0,4'd0), E(4'd0, 4'd0, 0, 0, 1, 8'd0));
    add(S(0,0,0,0,4'd0), E(4'd0, 4'd0, 0, 0, 0, 8'd0));
    qe = 4'd0; we = 8'd0;
    n = 0;
    while (stq.size() > 0) begin
      s = stq.pop_front();
      @(negedge clk);
      rst = s.r; start = s.s; stop = s.p; mode = s.m; limit = s.l;
      #1;
      ex = sb.pop_front();
      ob = {q, t_en, tff_rst, busy, done, wraps};
      checks++;
      if (ob !== ex) begin
        failures++;
        $display("FAIL reset_midrun cyc%0d got=%h exp=%h", n, ob, ex);
      end
      n++;
    end
  endtask

  task automatic test_corners;
    stim_t s; logic [18:0] ex, ob; int n; logic [7:0] w;
    // limit=15 auto-reload: full 0..15 sweep then wrap to 0.
    add(S(0,1,0,1,4'd15), E(qe, 4'd0, 0, 0, 0, we));
    add(S(0,0,0,0,4'd0), E(qe, 4'd0, 1, 1, 0, 8'd0));
    for (int i = 0; i < 16; i++)
      add(S(0,0,0,0,4'd0), E(4'(i), (i == 15) ? 4'd15 : inc(4'(i)), 0, 1, 0, 8'd0));
    add(S(0,0,1,0,4'd0), E(4'd0, 4'd0, 0, 1, 0, 8'd1));
    add(S(0,0,0,0,4'd0), E(4'd0, 4'd0, 0, 0, 0, 8'd1));
    // limit=0 auto-reload: bank stays 0, wraps every cycle, saturates at 255.
    add(S(0,1,0,1,4'd0), E(4'd0, 4'd0, 0, 0, 0, 8'd1));
    add(S(0,0,0,0,4'd0), E(4'd0, 4'd0, 1, 1, 0, 8'd0));
    for (int k = 0; k < 260; k++) begin
      w = (k > 255) ? 8'd255 : 8'(k);
      add(S(0,0,0,0,4'd0), E(4'd0, 4'd0, 0, 1, 0, w));
    end
    add(S(0,0,1,0,4'd0), E(4'd0, 4'd0, 0, 1, 0, 8'd255));
    add(S(0,0,0,0,4'd0), E(4'd0, 4'd0, 0, 0, 0, 8'd255));
    // Stop during CLEAR returns to IDLE.
    add(S(0,1,0,1,4'd7), E(4'd0, 4'd0, 0, 0, 0, 8'd255));
    add(S(0,0,1,0,4'd7), E(4'd0, 4'd0, 1, 1, 0, 8'd0));
    add(S(0,0,0,0,4'd7), E(4'd0, 4'd0, 0, 0, 0, 8'd0));
    add(S(0,0,0,0,4'd7), E(4'd0, 4'd0, 0, 0, 0, 8'd0));
    qe = 4'd0; we = 8'd0;
    n = 0;
    while (stq.size() > 0) begin
      s = stq.pop_front();
      @(negedge clk);
      rst = s.r; start = s.s; stop = s.p; mode = s.m; limit = s.l;
      #1;
      ex = sb.pop_front();
      ob = {q, t_en, tff_rst, busy, done, wraps};
      checks++;
      if (ob !== ex) begin
        failures++;
        $display("FAIL corners cyc%0d got=%h exp=%h", n, ob, ex);
      end
      n++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 1'b0;
    limit = 4'd0;
    qe    = 4'd0;
    we    = 8'd0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_stop();
    test_reset_midrun();
    test_corners();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tff_count_ctrl.md
TFF_COUNT_CTRL -- requirements
Module: tff_count_ctrl

Interface
REQ-001 Parameter: W, 4, width of the external T flip-flop bank under control (2..8).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: start  input  1  begin a count run; honoured only in IDLE.
REQ-005 Port: stop  input  1  abort an active run.
REQ-006 Port: mode  input  1  run type: 0 one-shot, 1 auto-reload; sampled with start.
REQ-007 Port: limit  input  W  terminal count; sampled with start.
REQ-008 Port: q_in  input  W  q outputs of the external TFF bank.
REQ-009 Port: t_en  output  W  t inputs to the external TFF bank.
REQ-010 Port: tff_rst  output  1  synchronous reset to the external TFF bank.
REQ-011 Port: busy  output  1  high in CLEAR and COUNT.
REQ-012 Port: done  output  1  one-cycle pulse at one-shot completion.
REQ-013 Port: wraps  output  8  auto-reload wrap count, saturating.

Function
REQ-014 The FSM SHALL have states IDLE, CLEAR, COUNT and DONE, encoded in a registered state vector.
REQ-015 The TFF bank SHALL be treated as clocked on clk: a t_en value presented in cycle n is reflected on q_in in cycle n+1.
REQ-016 IDLE: t_en=0, tff_rst=0; start=1 -> latch limit and mode, clear wraps to 0, go to CLEAR.
REQ-017 CLEAR: tff_rst=1 and t_en=0 for exactly one cycle; next state COUNT.
REQ-018 COUNT, q_in != latched limit: t_en[0]=1 and t_en[i]=&q_in[i-1:0] for i>0 (binary increment pattern).
REQ-019 COUNT, q_in == limit with mode=1: t_en=q_in (bank returns to 0 next cycle), wraps increments by 1, saturating at 255; state stays in COUNT.
REQ-020 COUNT, q_in == limit with mode=0: t_en=0; next state DONE.
REQ-021 DONE: done=1 for one cycle and t_en=0; next state IDLE; the bank holds the limit value.
REQ-022 limit=0: a one-shot reaches DONE on the first COUNT cycle; an auto-reload run holds the bank at 0 and increments wraps every cycle.
REQ-023 stop=1 in CLEAR or COUNT: t_en=0 in that same cycle (combinational), no done pulse, next state IDLE; stop takes priority over the terminal-count check.
REQ-024 start is ignored outside IDLE; stop is ignored in IDLE and DONE.
REQ-025 Limit and mode changes after start SHALL NOT affect the active run.
REQ-026 t_en SHALL be combinational from state, q_in and the latched limit; tff_rst, busy and done SHALL be decoded from state only.

Reset
REQ-027 rst=1 at a clock edge SHALL force state IDLE, wraps=0 and the latched limit and mode to 0, overriding start and stop.
REQ-028 While rst=1: tff_rst=1, t_en=0, busy=0, done=0; a run in progress SHALL be abandoned without a done pulse.
REQ-029 After rst deasserts, the first start SHALL be accepted in the next IDLE cycle.

Verification
REQ-030 The bench SHALL model a W=4 TFF bank (q toggles when t=1, clears on tff_rst) driven by clk with a 100 ns period.
REQ-031 One-shot, limit=5: start -> 1 CLEAR cycle, q_in steps 0..5 over 6 COUNT cycles, done pulses once, busy low afterwards, q_in holds 5.
REQ-032 Auto-reload, limit=3: q_in sequence 0,1,2,3,0,1,2,3,0; wraps=2 after the second 3->0 transition; done never asserted.
REQ-033 Stop mid-run, limit=9, stop when q_in=4: t_en=0 in the same cycle, q_in holds 4, IDLE next cycle, no done pulse.
REQ-034 Reset mid-run, auto-reload with limit=2 and wraps=3: rst pulse -> wraps=0, busy=0, q_in=0 next cycle; start is ignored during rst.
REQ-035 Corner cases: limit=0 one-shot gives done 3 cycles after start; limit=15 auto-reload gives a full 0..15 wrap; start asserted in COUNT and DONE is ignored.
